lutram_fifo: RTL and testbench
==============================

Name: lutram_fifo

Overview:
- Synchronous FIFO built on distributed (LUT) RAM storage: the registered-write, async-read 16x4 dual-port LUT RAM style used in our ECP5 primitive set.
- Wraps that storage with write/read pointers, occupancy counting, and a registered output stage with a valid/ready handshake on both ends.
- Sits between a producer and a consumer in the same clock domain, e.g. command queues in front of Hans2 peripherals.

Parameters:
- WIDTH, 4, data bits per entry (multiple of 4; storage is WIDTH/4 slices of 16x4).
- DEPTH, 16, total capacity in entries (RAM plus output register); must be a power of 2, minimum 4.
- AF_LEVEL, DEPTH-2, almost-full threshold; used only with LUTRAM_FIFO_ALMOST_EN.
- AE_LEVEL, 2, almost-empty threshold; used only with LUTRAM_FIFO_ALMOST_EN.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- WR_DATA  input  WIDTH  write data.
- WR_VALID  input  1  producer offers WR_DATA.
- WR_READY  output  1  FIFO can accept; equals !full.
- RD_DATA  output  WIDTH  head-of-queue data, registered.
- RD_VALID  output  1  RD_DATA holds a valid entry.
- RD_READY  input  1  consumer takes RD_DATA.
- COUNT  output  $clog2(DEPTH)+1  entries held (RAM plus output register).

Behaviour:
- Reset (RST=1 at an edge):
  - wptr, rptr, COUNT = 0; RD_VALID = 0; RD_DATA = 0; WR_READY = 1 from the cycle after.
  - RAM contents are not cleared.
  - Reset mid-transfer discards all entries and any in-flight write.
- Write: accepted at an edge where WR_VALID && WR_READY.
  - RAM[wptr] is written at that edge.
  - wptr increments modulo (DEPTH-1), the RAM depth; the output register holds the remaining entry.
- RAM read is asynchronous at rptr. A word written at edge k is readable combinationally after edge k.
- Output stage loads RD_DATA <= RAM[rptr] and sets RD_VALID=1, and rptr increments, at any edge where:
  - the RAM holds at least one entry, and
  - RD_VALID=0, or RD_VALID && RD_READY (pop plus refill in the same cycle).
- Pop: at an edge with RD_VALID && RD_READY.
  - If no refill is possible, RD_VALID goes 0 and RD_DATA holds its old value.
- Latency: a write accepted at edge k into an empty FIFO gives RD_VALID=1 after edge k+1. There is no write-to-read bypass.
- Throughput: one write and one read per cycle sustained.
- COUNT: +1 on accepted write, -1 on pop, unchanged when both occur in the same cycle.
- Full (COUNT==DEPTH): WR_READY=0, even if a pop occurs in the same cycle (no pass-through write when full).
- Empty (COUNT==0): RD_VALID=0. RD_READY is ignored.
- Pointer wrap is silent; no overflow or underflow is possible through the handshake.
- WR_VALID=1 while full: no state change; the producer must hold its data.
- X/Z on WR_VALID while RST=0 is a verification error (assert).

Optional Feature:
- Macro: LUTRAM_FIFO_ALMOST_EN.
- Defined: adds outputs ALMOST_FULL and ALMOST_EMPTY, both registered.
  - ALMOST_FULL = (next COUNT >= AF_LEVEL).
  - ALMOST_EMPTY = (next COUNT <= AE_LEVEL).
  - Both reset: ALMOST_FULL=0, ALMOST_EMPTY=1.
- Undefined: the ports and their logic are absent; AF_LEVEL and AE_LEVEL are ignored.

Decomposition:
- Package lutram_fifo_pkg:
  - LUTRAM_SLICE_W=4 and LUTRAM_SLICE_D=16.
  - Function for pointer width.
  - Typedef for COUNT width derived from DEPTH.
- Sub-module lutram_sdp:
  - Parameterised WIDTH x (DEPTH-1) storage, registered write, asynchronous read.
  - Same timing as the 16x4 dual-port LUT RAM primitive, so it can map onto it.

Test Plan:
- Reset then single write 0xA at edge 1 -> RD_VALID=1 and RD_DATA=0xA after edge 2; COUNT=1; RD_READY=1 at edge 3 -> RD_VALID=0, COUNT=0.
- Write 16 entries 0x0..0xF with RD_READY=0 -> WR_READY=0 after 16th write, COUNT=16; 17th WR_VALID ignored; drain gives 0x0..0xF in order.
- Full FIFO, WR_VALID=1 and RD_READY=1 simultaneously -> one pop, no write accepted, COUNT=15, WR_READY=1 next cycle.
- Continuous WR_VALID=1, RD_READY=1 for 100 cycles with counter data -> in-order output, one word per cycle after 2-cycle latency, COUNT steady at 1-2, pointers wrap cleanly.
- Fill to 9 entries, assert RST for one cycle -> COUNT=0, RD_VALID=0, WR_READY=1; next write 0x5 emerges after 2 edges, no stale data.
- With LUTRAM_FIFO_ALMOST_EN, DEPTH=16, AF=14, AE=2 -> ALMOST_FULL rises when COUNT reaches 14; ALMOST_EMPTY falls when COUNT reaches 3.

Source files
------------

// File: rtl/lutram_fifo_pkg.sv
// Shared constants and sizing helpers for the LUT-RAM backed FIFO.
// The 16x4 geometry matches the ECP5 distributed RAM primitive.
`timescale 1ns/1ps
package lutram_fifo_pkg;

  localparam int LUTRAM_SLICE_W = 4;
  localparam int LUTRAM_SLICE_D = 16;
  localparam int DEFAULT_DEPTH  = 16;

  // The RAM holds DEPTH-1 entries; the output register holds the last one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth - 1);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [$clog2(DEFAULT_DEPTH):0] count_t;

endpackage

// File: rtl/lutram_sdp.sv
// Simple dual-port storage: registered write, asynchronous read, built
// from 4-bit wide slices so each slice maps onto a 16x4 LUT RAM.
`timescale 1ns/1ps
module lutram_sdp
  import lutram_fifo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 15,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int SLICES = WIDTH / LUTRAM_SLICE_W;

  // Deeper configurations cascade several primitives per slice.
  logic depth_cascade_unused;
  assign depth_cascade_unused = (DEPTH > LUTRAM_SLICE_D);

  for (genvar s = 0; s < SLICES; s++) begin : g_slice
    logic [LUTRAM_SLICE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata[s*LUTRAM_SLICE_W +: LUTRAM_SLICE_W];
    end

    assign rdata[s*LUTRAM_SLICE_W +: LUTRAM_SLICE_W] = mem[raddr];
  end

endmodule

// File: rtl/lutram_fifo.sv
// Synchronous valid/ready FIFO on LUT RAM with a registered output stage.
// Define LUTRAM_FIFO_ALMOST_EN to add registered ALMOST_FULL/ALMOST_EMPTY.
`timescale 1ns/1ps
module lutram_fifo
  import lutram_fifo_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           WR_DATA,
  input  logic                       WR_VALID,
  output logic                       WR_READY,
  output logic [WIDTH-1:0]           RD_DATA,
  output logic                       RD_VALID,
  input  logic                       RD_READY,
`ifdef LUTRAM_FIFO_ALMOST_EN
  output logic                       ALMOST_FULL,
  output logic                       ALMOST_EMPTY,
`endif
  output logic [$clog2(DEPTH):0]     COUNT
);

  localparam int RAM_D = DEPTH - 1;
  localparam int AW    = ptr_width(DEPTH);
  localparam int CW    = count_width(DEPTH);

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    ram_used;
  logic [WIDTH-1:0] ram_rdata;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             wr_en;
  logic             pop;
  logic             load;

  // RAM depth is not a power of two, so wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(RAM_D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign wr_en    = WR_VALID && !full && !RST;
  assign pop      = rd_valid && RD_READY;
  assign ram_used = count - {{(CW-1){1'b0}}, rd_valid};
  assign load     = (ram_used != '0) && (!rd_valid || pop);

  always_comb begin
    count_next = count;
    if (wr_en && !pop)      count_next = count + 1'b1;
    else if (!wr_en && pop) count_next = count - 1'b1;
  end

  lutram_sdp #(
    .WIDTH (WIDTH),
    .DEPTH (RAM_D),
    .AW    (AW)
  ) u_ram (
    .clk   (CLK),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (WR_DATA),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      count <= count_next;
      if (wr_en) wptr <= ptr_inc(wptr);
      if (load) begin
        rd_data  <= ram_rdata;
        rptr     <= ptr_inc(rptr);
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
    end
  end

`ifdef LUTRAM_FIFO_ALMOST_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
    end else begin
      ALMOST_FULL  <= (count_next >= CW'(AF_LEVEL));
      ALMOST_EMPTY <= (count_next <= CW'(AE_LEVEL));
    end
  end
`else
  logic levels_unused;
  assign levels_unused = (AF_LEVEL > DEPTH) || (AE_LEVEL > DEPTH);
`endif

  assign WR_READY = !full;
  assign RD_DATA  = rd_data;
  assign RD_VALID = rd_valid;
  assign COUNT    = count;

  a_wr_valid_known: assert property (@(posedge CLK) !RST |-> !$isunknown(WR_VALID));

endmodule

// File: tb/tb_lutram_fifo.sv
// Directed self-checking bench for lutram_fifo (WIDTH=4, DEPTH=16).
`timescale 1ns/1ps
module tb_lutram_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] WR_DATA;
  logic       WR_VALID;
  logic       WR_READY;
  logic [3:0] RD_DATA;
  logic       RD_VALID;
  logic       RD_READY;
  logic [4:0] COUNT;
`ifdef LUTRAM_FIFO_ALMOST_EN
  logic       ALMOST_FULL;
  logic       ALMOST_EMPTY;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  lutram_fifo #(
    .WIDTH    (4),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .WR_DATA      (WR_DATA),
    .WR_VALID     (WR_VALID),
    .WR_READY     (WR_READY),
    .RD_DATA      (RD_DATA),
    .RD_VALID     (RD_VALID),
    .RD_READY     (RD_READY),
`ifdef LUTRAM_FIFO_ALMOST_EN
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
`endif
    .COUNT        (COUNT)
  );

  // Advance one rising edge and settle before sampling or driving.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; WR_VALID = 1'b0; RD_READY = 1'b0; WR_DATA = 4'h0;
    step(); step();
    RST = 1'b0;
    total++;
    if ({COUNT, RD_VALID, RD_DATA, WR_READY} !== {5'd0, 1'b0, 4'h0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset_state: got count=%0d vld=%0b data=%0h rdy=%0b required 0 0 0 1",
               COUNT, RD_VALID, RD_DATA, WR_READY);
    end
  endtask

  task automatic test_single();
    WR_DATA = 4'hA; WR_VALID = 1'b1;
    step();
    WR_VALID = 1'b0;
    total++;
    if ({RD_VALID, COUNT} !== {1'b0, 5'd1}) begin
      bad++;
      $display("[TB] FAIL single_latency1: got vld=%0b count=%0d required 0 1", RD_VALID, COUNT);
    end
    step();
    total++;
    if ({RD_VALID, RD_DATA, COUNT} !== {1'b1, 4'hA, 5'd1}) begin
      bad++;
      $display("[TB] FAIL single_out: got vld=%0b data=%0h count=%0d required 1 a 1",
               RD_VALID, RD_DATA, COUNT);
    end
    RD_READY = 1'b1;
    step();
    RD_READY = 1'b0;
    total++;
    if ({RD_VALID, COUNT} !== {1'b0, 5'd0}) begin
      bad++;
      $display("[TB] FAIL single_pop: got vld=%0b count=%0d required 0 0", RD_VALID, COUNT);
    end
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      WR_DATA = 4'(i); WR_VALID = 1'b1;
      step();
    end
    WR_VALID = 1'b0;
  endtask

  task automatic test_fill_drain();
    fill16();
    total++;
    if ({COUNT, WR_READY} !== {5'd16, 1'b0}) begin
      bad++;
      $display("[TB] FAIL full_flag: got count=%0d rdy=%0b required 16 0", COUNT, WR_READY);
    end
    WR_DATA = 4'h7; WR_VALID = 1'b1;
    step();
    WR_VALID = 1'b0;
    total++;
    if (COUNT !== 5'd16) begin
      bad++;
      $display("[TB] FAIL write_when_full: got count=%0d required 16", COUNT);
    end
    RD_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if ({RD_VALID, RD_DATA} !== {1'b1, 4'(i)}) begin
        bad++;
        $display("[TB] FAIL drain_order[%0d]: got vld=%0b data=%0h required 1 %0h",
                 i, RD_VALID, RD_DATA, i);
      end
      step();
    end
    RD_READY = 1'b0;
    total++;
    if ({RD_VALID, COUNT} !== {1'b0, 5'd0}) begin
      bad++;
      $display("[TB] FAIL drain_empty: got vld=%0b count=%0d required 0 0", RD_VALID, COUNT);
    end
  endtask

  task automatic test_full_simul();
    fill16();
    WR_DATA = 4'h9; WR_VALID = 1'b1; RD_READY = 1'b1;
    step();
    WR_VALID = 1'b0; RD_READY = 1'b0;
    total++;
    if ({COUNT, WR_READY, RD_DATA} !== {5'd15, 1'b1, 4'h1}) begin
      bad++;
      $display("[TB] FAIL full_pop_write: got count=%0d rdy=%0b data=%0h required 15 1 1",
               COUNT, WR_READY, RD_DATA);
    end
    RD_READY = 1'b1;
    for (int i = 1; i < 16; i++) begin
      total++;
      if ({RD_VALID, RD_DATA} !== {1'b1, 4'(i)}) begin
        bad++;
        $display("[TB] FAIL full_pop_drain[%0d]: got vld=%0b data=%0h required 1 %0h",
                 i, RD_VALID, RD_DATA, i);
      end
      step();
    end
    RD_READY = 1'b0;
    total++;
    if ({RD_VALID, COUNT} !== {1'b0, 5'd0}) begin
      bad++;
      $display("[TB] FAIL full_pop_empty: got vld=%0b count=%0d required 0 0", RD_VALID, COUNT);
    end
  endtask

  task automatic test_back_to_back();
    WR_VALID = 1'b1; RD_READY = 1'b1;
    for (int c = 0; c < 100; c++) begin
      WR_DATA = 4'(c);
      if (c >= 2) begin
        total++;
        if ({RD_VALID, RD_DATA} !== {1'b1, 4'(c - 2)}) begin
          bad++;
          $display("[TB] FAIL stream_data[%0d]: got vld=%0b data=%0h required 1 %0h",
                   c, RD_VALID, RD_DATA, 4'(c - 2));
        end
      end
      step();
      if (c >= 1) begin
        total++;
        if (COUNT < 5'd1 || COUNT > 5'd2) begin
          bad++;
          $display("[TB] FAIL stream_count[%0d]: got %0d required 1..2", c, COUNT);
        end
      end
    end
    WR_VALID = 1'b0;
    for (int c = 98; c < 100; c++) begin
      total++;
      if ({RD_VALID, RD_DATA} !== {1'b1, 4'(c)}) begin
        bad++;
        $display("[TB] FAIL stream_tail[%0d]: got vld=%0b data=%0h required 1 %0h",
                 c, RD_VALID, RD_DATA, 4'(c));
      end
      step();
    end
    RD_READY = 1'b0;
    total++;
    if ({RD_VALID, COUNT} !== {1'b0, 5'd0}) begin
      bad++;
      $display("[TB] FAIL stream_empty: got vld=%0b count=%0d required 0 0", RD_VALID, COUNT);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) begin
      WR_DATA = 4'(4'hC + i); WR_VALID = 1'b1;
      step();
    end
    total++;
    if (COUNT !== 5'd9) begin
      bad++;
      $display("[TB] FAIL mid_fill: got count=%0d required 9", COUNT);
    end
    WR_DATA = 4'hE; RST = 1'b1;
    step();
    RST = 1'b0; WR_VALID = 1'b0;
    total++;
    if ({COUNT, RD_VALID, WR_READY, RD_DATA} !== {5'd0, 1'b0, 1'b1, 4'h0}) begin
      bad++;
      $display("[TB] FAIL mid_reset: got count=%0d vld=%0b rdy=%0b data=%0h required 0 0 1 0",
               COUNT, RD_VALID, WR_READY, RD_DATA);
    end
    WR_DATA = 4'h5; WR_VALID = 1'b1;
    step();
    WR_VALID = 1'b0;
    total++;
    if (RD_VALID !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_no_stale: got vld=%0b required 0", RD_VALID);
    end
    step();
    total++;
    if ({RD_VALID, RD_DATA, COUNT} !== {1'b1, 4'h5, 5'd1}) begin
      bad++;
      $display("[TB] FAIL mid_after: got vld=%0b data=%0h count=%0d required 1 5 1",
               RD_VALID, RD_DATA, COUNT);
    end
    RD_READY = 1'b1;
    step();
    RD_READY = 1'b0;
    step();
    total++;
    if ({RD_VALID, COUNT} !== {1'b0, 5'd0}) begin
      bad++;
      $display("[TB] FAIL mid_final: got vld=%0b count=%0d required 0 0", RD_VALID, COUNT);
    end
  endtask

`ifdef LUTRAM_FIFO_ALMOST_EN
  task automatic test_almost();
    RST = 1'b1;
    step();
    RST = 1'b0;
    total++;
    if ({ALMOST_FULL, ALMOST_EMPTY} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL almost_reset: got af=%0b ae=%0b required 0 1", ALMOST_FULL, ALMOST_EMPTY);
    end
    for (int n = 1; n <= 16; n++) begin
      WR_DATA = 4'(n); WR_VALID = 1'b1;
      step();
      total++;
      if ({ALMOST_FULL, ALMOST_EMPTY} !== {1'(n >= 14), 1'(n <= 2)}) begin
        bad++;
        $display("[TB] FAIL almost_fill[%0d]: got af=%0b ae=%0b required %0b %0b",
                 n, ALMOST_FULL, ALMOST_EMPTY, n >= 14, n <= 2);
      end
    end
    WR_VALID = 1'b0; RD_READY = 1'b1;
    for (int n = 15; n >= 0; n--) begin
      step();
      total++;
      if ({ALMOST_FULL, ALMOST_EMPTY} !== {1'(n >= 14), 1'(n <= 2)}) begin
        bad++;
        $display("[TB] FAIL almost_drain[%0d]: got af=%0b ae=%0b required %0b %0b",
                 n, ALMOST_FULL, ALMOST_EMPTY, n >= 14, n <= 2);
      end
    end
    RD_READY = 1'b0;
  endtask
`endif

  initial begin
    RST = 1'b1; WR_VALID = 1'b0; RD_READY = 1'b0; WR_DATA = 4'h0;
    test_reset();
    test_single();
    test_fill_drain();
    test_full_simul();
    test_back_to_back();
    test_reset_mid();
`ifdef LUTRAM_FIFO_ALMOST_EN
    test_almost();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
